// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one external memory bus between the cpu6502 core and a DMA requester.
// The core is stalled through cpu_ready while the DMA owns the bus. DMA bursts are bounded
// by MAX_BURST beats, and at least CPU_MIN_SLOTS core cycles separate consecutive bursts.
// Optional feature macro: BUS_ARBITER_STATS_EN adds saturating beat/stall counters.
module bus_arbiter #(
    parameter int unsigned MAX_BURST     = 4,
    parameter int unsigned CPU_MIN_SLOTS = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_read_write,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_data_out,
    input  logic        dma_read_write,
    input  logic        dma_last,
    output logic        dma_grant,
    output logic        dma_ack,
    output logic [7:0]  dma_data_in,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    output logic        mem_read_write,
`ifdef BUS_ARBITER_STATS_EN
    output logic [15:0] stat_dma_beats,
    output logic [15:0] stat_cpu_stall,
`endif
    input  logic [7:0]  mem_data_in
);

    typedef enum logic [1:0] {
        StCpuOwn,
        StHandover,
        StDmaOwn,
        StReturn
    } state_e;

    localparam logic [8:0] BurstLen = 9'(MAX_BURST);
    localparam logic [7:0] MinSlots = 8'(CPU_MIN_SLOTS);

    state_e     state_q, state_d;
    logic [7:0] beat_q, beat_d;
    logic [7:0] guard_q, guard_d;
    logic [8:0] beat_inc;

    // Widened so the terminal-count compare cannot wrap at 255.
    assign beat_inc = {1'b0, beat_q} + 9'd1;

    // Read data goes to both masters straight from memory.
    assign cpu_data_in = mem_data_in;
    assign dma_data_in = mem_data_in;

    // State, beat and guard registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= StCpuOwn;
            beat_q  <= 8'd0;
            guard_q <= 8'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            guard_q <= guard_d;
        end
    end

    // Next-state logic and bus multiplexing.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        guard_d        = guard_q;
        cpu_ready      = 1'b1;
        dma_grant      = 1'b0;
        dma_ack        = 1'b0;
        mem_address    = cpu_address;
        mem_data_out   = cpu_data_out;
        mem_read_write = cpu_read_write;

        unique case (state_q)
            StCpuOwn: begin
                if (dma_req && (guard_q == 8'd0)) begin
                    state_d = StHandover;
                end else if (guard_q != 8'd0) begin
                    guard_d = guard_q - 8'd1;
                end
            end
            StHandover: begin
                // Dead cycle: core address stays on the bus but only as a read.
                cpu_ready      = 1'b0;
                mem_read_write = 1'b0;
                beat_d         = 8'd0;
                state_d        = StDmaOwn;
            end
            StDmaOwn: begin
                cpu_ready      = 1'b0;
                dma_grant      = 1'b1;
                dma_ack        = dma_req;
                mem_address    = dma_address;
                mem_data_out   = dma_data_out;
                mem_read_write = dma_read_write;
                if (dma_req) begin
                    beat_d = beat_q + 8'd1;
                    if (dma_last || (beat_inc == BurstLen)) begin
                        state_d = StReturn;
                    end
                end else begin
                    state_d = StReturn;
                end
            end
            StReturn: begin
                cpu_ready      = 1'b0;
                mem_read_write = 1'b0;
                guard_d        = MinSlots;
                state_d        = StCpuOwn;
            end
            default: begin
                state_d = StCpuOwn;
            end
        endcase

        // While reset is held, never issue a write on the bus.
        if (!reset) begin
            cpu_ready      = 1'b1;
            dma_grant      = 1'b0;
            dma_ack        = 1'b0;
            mem_read_write = 1'b0;
        end
    end

`ifdef BUS_ARBITER_STATS_EN
    // Saturating counters of acked beats and core stall cycles.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            stat_dma_beats <= 16'd0;
            stat_cpu_stall <= 16'd0;
        end else begin
            if (dma_ack && (stat_dma_beats != 16'hFFFF)) begin
                stat_dma_beats <= stat_dma_beats + 16'd1;
            end
            if (!cpu_ready && (stat_cpu_stall != 16'hFFFF)) begin
                stat_cpu_stall <= stat_cpu_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus for bus_arbiter, checked every cycle against a
// bus-ownership model plus hand-computed expectations for each scenario.
module tb_bus_arbiter;

    localparam int unsigned MaxBurst = 4;
    localparam int unsigned MinSlots = 1;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic        cpu_read_write;
    logic [7:0]  cpu_data_in;
    logic        cpu_ready;
    logic        dma_req;
    logic [15:0] dma_address;
    logic [7:0]  dma_data_out;
    logic        dma_read_write;
    logic        dma_last;
    logic        dma_grant;
    logic        dma_ack;
    logic [7:0]  dma_data_in;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_out;
    logic        mem_read_write;
    logic [7:0]  mem_data_in = 8'h00;
`ifdef BUS_ARBITER_STATS_EN
    logic [15:0] stat_dma_beats;
    logic [15:0] stat_cpu_stall;
`endif

    bus_arbiter #(
        .MAX_BURST     (MaxBurst),
        .CPU_MIN_SLOTS (MinSlots)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .cpu_address    (cpu_address),
        .cpu_data_out   (cpu_data_out),
        .cpu_read_write (cpu_read_write),
        .cpu_data_in    (cpu_data_in),
        .cpu_ready      (cpu_ready),
        .dma_req        (dma_req),
        .dma_address    (dma_address),
        .dma_data_out   (dma_data_out),
        .dma_read_write (dma_read_write),
        .dma_last       (dma_last),
        .dma_grant      (dma_grant),
        .dma_ack        (dma_ack),
        .dma_data_in    (dma_data_in),
        .mem_address    (mem_address),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write),
`ifdef BUS_ARBITER_STATS_EN
        .stat_dma_beats (stat_dma_beats),
        .stat_cpu_stall (stat_cpu_stall),
`endif
        .mem_data_in    (mem_data_in)
    );

    always #5 clk_in = ~clk_in;

    // Memory read data changes every cycle so pass-through is observable.
    always @(posedge clk_in) mem_data_in <= mem_data_in + 8'h37;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the bus, whether this is a dead turnaround cycle,
    // beats taken in the current burst, and core cycles still owed before a new grant.
    bit m_dma_owns;
    bit m_dead;
    bit m_dead_leads_to_dma;
    int m_beats;
    int m_owed;
    int m_stat_beats;
    int m_stat_stall;

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            m_dma_owns          <= 1'b0;
            m_dead              <= 1'b0;
            m_dead_leads_to_dma <= 1'b0;
            m_beats             <= 0;
            m_owed              <= 0;
            m_stat_beats        <= 0;
            m_stat_stall        <= 0;
        end else begin
            if (m_dma_owns && dma_req && m_stat_beats < 65535) m_stat_beats <= m_stat_beats + 1;
            if ((m_dma_owns || m_dead) && m_stat_stall < 65535) m_stat_stall <= m_stat_stall + 1;
            if (m_dead) begin
                m_dead <= 1'b0;
                if (m_dead_leads_to_dma) begin
                    m_dma_owns <= 1'b1;
                    m_beats    <= 0;
                end else begin
                    m_owed <= MinSlots;
                end
            end else if (m_dma_owns) begin
                if (!dma_req || dma_last || (m_beats + 1 == MaxBurst)) begin
                    m_dma_owns          <= 1'b0;
                    m_dead              <= 1'b1;
                    m_dead_leads_to_dma <= 1'b0;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end else if (dma_req && m_owed == 0) begin
                m_dead              <= 1'b1;
                m_dead_leads_to_dma <= 1'b1;
            end else if (m_owed > 0) begin
                m_owed <= m_owed - 1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("cpu_ready", 32'(cpu_ready), 32'(!(m_dma_owns || m_dead)));
            chk("dma_grant", 32'(dma_grant), 32'(m_dma_owns));
            chk("dma_ack", 32'(dma_ack), 32'(m_dma_owns && dma_req));
            chk("mem_address", 32'(mem_address), 32'(m_dma_owns ? dma_address : cpu_address));
            chk("mem_data_out", 32'(mem_data_out), 32'(m_dma_owns ? dma_data_out : cpu_data_out));
            chk("mem_read_write", 32'(mem_read_write),
                32'(!reset ? 1'b0 : m_dma_owns ? dma_read_write : m_dead ? 1'b0 : cpu_read_write));
            chk("cpu_data_in", 32'(cpu_data_in), 32'(mem_data_in));
            chk("dma_data_in", 32'(dma_data_in), 32'(mem_data_in));
`ifdef BUS_ARBITER_STATS_EN
            chk("stat_dma_beats", 32'(stat_dma_beats), 32'(m_stat_beats));
            chk("stat_cpu_stall", 32'(stat_cpu_stall), 32'(m_stat_stall));
`endif
        end
    end

    task automatic at_edge();
        @(posedge clk_in);
        #1;
    endtask

    int stall;
    int acks;
    int gap;
    bit ended;

    initial begin
        cpu_address    = 16'h1234;
        cpu_data_out   = 8'h11;
        cpu_read_write = 1'b0;
        dma_req        = 1'b1;
        dma_address    = 16'h4000;
        dma_data_out   = 8'hC3;
        dma_read_write = 1'b0;
        dma_last       = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk_in);
        chk_en = 1'b1;

        // Reset held with a pending request.
        @(negedge clk_in);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_grant", 32'(dma_grant), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'h1234);

        // Release: one core cycle, then handover.
        at_edge();
        reset = 1'b1;
        @(negedge clk_in);
        chk("rel_ready", 32'(cpu_ready), 32'd1);
        @(negedge clk_in);
        chk("handover", {30'd0, cpu_ready, dma_grant}, 32'd0);

        // Held request: full burst, stall length and core window between bursts.
        stall = 1;
        acks  = 0;
        ended = 1'b0;
        for (int i = 0; i < 20 && !ended; i++) begin
            @(negedge clk_in);
            if (cpu_ready) ended = 1'b1;
            else begin
                stall++;
                acks += int'(dma_ack);
            end
        end
        chk("burst_stall", 32'(stall), 32'd6);
        chk("burst_acks", 32'(acks), 32'd4);
        gap   = 1;
        ended = 1'b0;
        for (int i = 0; i < 20 && !ended; i++) begin
            @(negedge clk_in);
            if (!cpu_ready) ended = 1'b1;
            else gap++;
        end
        chk("core_window", 32'(gap), 32'd2);
        at_edge();
        dma_req = 1'b0;
        repeat (4) at_edge();

        // Two-beat write burst terminated by dma_last.
        dma_req        = 1'b1;
        dma_address    = 16'h0200;
        dma_data_out   = 8'hAA;
        dma_read_write = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("wr1", {mem_read_write, dma_ack, mem_data_out, mem_address}, {8'd0, 1'b1, 1'b1, 8'hAA, 16'h0200});
        at_edge();
        dma_address  = 16'h0201;
        dma_data_out = 8'h55;
        dma_last     = 1'b1;
        @(negedge clk_in);
        chk("wr2", {mem_read_write, dma_ack, mem_data_out, mem_address}, {8'd0, 1'b1, 1'b1, 8'h55, 16'h0201});
        at_edge();
        dma_req        = 1'b0;
        dma_last       = 1'b0;
        dma_read_write = 1'b0;
        @(negedge clk_in);
        chk("wr_return", {29'd0, dma_grant, cpu_ready, mem_read_write}, 32'd0);
        repeat (3) at_edge();

        // Request withdrawn after one beat.
        cpu_address = 16'h8000;
        dma_address = 16'h0300;
        dma_req     = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("drop_ack1", 32'(dma_ack), 32'd1);
        at_edge();
        dma_req = 1'b0;
        @(negedge clk_in);
        chk("drop_noack", {30'd0, dma_grant, dma_ack}, 32'd2);
        @(negedge clk_in);
        chk("drop_return", {30'd0, dma_grant, cpu_ready}, 32'd0);
        @(negedge clk_in);
        chk("drop_cpu_addr", {15'd0, cpu_ready, mem_address}, {15'd0, 1'b1, 16'h8000});
        repeat (3) at_edge();

        // Asynchronous reset in the middle of a write burst.
        cpu_read_write = 1'b1;
        dma_read_write = 1'b1;
        dma_req        = 1'b1;
        repeat (4) @(posedge clk_in);
        #3 reset = 1'b0;
        #1;
        chk("areset_out", {28'd0, dma_grant, cpu_ready, mem_read_write, dma_ack}, 32'h4);
`ifdef BUS_ARBITER_STATS_EN
        chk("areset_stats", {stat_dma_beats, stat_cpu_stall}, 32'd0);
`endif
        at_edge();
        dma_req        = 1'b0;
        cpu_read_write = 1'b0;
        dma_read_write = 1'b0;
        at_edge();
        reset = 1'b1;
        repeat (2) at_edge();

        // Three full bursts back to back.
        dma_req = 1'b1;
        acks    = 0;
        stall   = 0;
        for (int i = 0; i < 80 && acks < 12; i++) begin
            @(negedge clk_in);
            if (!cpu_ready) stall++;
            acks += int'(dma_ack);
        end
        at_edge();
        dma_req = 1'b0;
        @(negedge clk_in);
        if (!cpu_ready) stall++;
        chk("three_acks", 32'(acks), 32'd12);
        chk("three_stall", 32'(stall), 32'd18);
        @(negedge clk_in);
`ifdef BUS_ARBITER_STATS_EN
        chk("stat_beats12", 32'(stat_dma_beats), 32'd12);
        chk("stat_stall18", 32'(stat_cpu_stall), 32'd18);
`endif
        chk("idle_ready", 32'(cpu_ready), 32'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
